cic_decimator: RTL and testbench

- Runtime-programmable cascaded integrator-comb (CIC) decimation filter. Unsigned 8-bit samples in, one per clk cycle; unsigned 8-bit decimated samples out.
- Sits between a full-rate sample source and a lower-rate consumer.
- Output rate is indicated by a decimated strobe/clock, d_clk.
- Gain is normalised so DC passes with unity gain when the ratio is a power of two.

---
 rtl/cic_decimator.sv | 117 +++++++++++
 tb/tb_cic_decimator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decimator.sv
// Runtime-programmable CIC decimator: STAGES integrators at full rate, STAGES combs at the decimated rate.
// Optional build macro CIC_SAT_EN clamps scaled results above 255 instead of truncating them.
module cic_decimator #(
  parameter int WIDTH  = 18,
  parameter int STAGES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] decimation_ratio,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        d_clk
);

  localparam int SHW = 8;

  logic [WIDTH-1:0] integ    [STAGES];
  logic [WIDTH-1:0] dly      [STAGES];
  logic [WIDTH-1:0] comb_tap [STAGES];
  logic [WIDTH-1:0] comb_in;
  logic [WIDTH-1:0] comb_out;
  logic             comb_en;
  logic [15:0]      r_lat;
  logic [15:0]      cnt;
  logic             first;
  logic [SHW-1:0]   shift_q;
  logic [15:0]      r_cur;
  logic [15:0]      r_eff;
  logic             wrap;
  logic [SHW-1:0]   shift_cur;
  logic [7:0]       y8;

  function automatic logic [4:0] clog2_16(input logic [15:0] r);
    logic [15:0] m;
    logic [4:0]  res;
    m   = r - 16'd1;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) res = 5'(i + 1);
    end
    return res;
  endfunction

  // The first cycle after reset uses the live ratio; later frames use the value latched at the wrap.
  always_comb begin
    r_cur     = first ? decimation_ratio : r_lat;
    r_eff     = (r_cur < 16'd2) ? 16'd1 : r_cur;
    wrap      = (cnt == (r_eff - 16'd1));
    shift_cur = SHW'(STAGES * int'(clog2_16(r_eff)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) integ[k] <= '0;
    end else begin
      integ[0] <= integ[0] + WIDTH'(d_in);
      for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first   <= 1'b1;
      r_lat   <= '0;
      cnt     <= '0;
      comb_en <= 1'b0;
      comb_in <= '0;
      shift_q <= '0;
    end else begin
      first   <= 1'b0;
      comb_en <= wrap;
      if (first || wrap) r_lat <= decimation_ratio;
      if (wrap) begin
        cnt     <= '0;
        comb_in <= integ[STAGES-1];
        shift_q <= shift_cur;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  always_comb begin : comb_chain
    logic [WIDTH-1:0] acc;
    acc = comb_in;
    for (int k = 0; k < STAGES; k++) begin
      comb_tap[k] = acc;
      acc         = acc - dly[k];
    end
    comb_out = acc;
  end

  always_comb begin
`ifdef CIC_SAT_EN
    logic [WIDTH-1:0] y_full;
    y_full = comb_out >> shift_q;
    y8     = (y_full > WIDTH'(255)) ? 8'hFF : y_full[7:0];
`else
    y8 = 8'(comb_out >> shift_q);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) dly[k] <= '0;
      d_out <= '0;
      d_clk <= 1'b0;
    end else begin
      d_clk <= comb_en;
      if (comb_en) begin
        for (int k = 0; k < STAGES; k++) dly[k] <= comb_tap[k];
        d_out <= y8;
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator: table-driven DC cases, hand sequences and a random run
// compared against a closed-form (binomial-weighted sum) model of the CIC response.
`timescale 1ns/1ps
module tb_cic_decimator;
  localparam int N = 3;
  localparam int W = 18;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] decimation_ratio = '0;
  logic [7:0]  d_in = '0;
  logic [7:0]  d_out;
  logic        d_clk;

  int checks = 0;
  int failures = 0;

  cic_decimator #(.WIDTH(W), .STAGES(N)) dut (
    .clk(clk), .rst(rst), .decimation_ratio(decimation_ratio),
    .d_in(d_in), .d_out(d_out), .d_clk(d_clk)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ratio;
    logic [7:0]  din;
    logic [7:0]  exp_out;
    int          period;
  } vec_t;

  vec_t vecs [7];

  // Reference model state: sample history since reset and the integrator sums taken at frame ends.
  longint     xs[$];
  longint     sf[$];
  int         e_idx, frame_end, cur_r;
  bit         pend;
  logic [7:0] pend_val;
  bit         exp_clk;
  logic [7:0] exp_out;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int reff(input logic [15:0] r);
    return (r < 16'd2) ? 1 : int'(r);
  endfunction

  function automatic int clog2i(input int r);
    int s = 0;
    while ((1 << s) < r) s++;
    return s;
  endfunction

  function automatic longint binom(input longint n, input int k);
    longint v = 1;
    if (k < 0 || n < longint'(k)) return 0;
    for (int i = 0; i < k; i++) v = v * (n - i) / (i + 1);
    return v;
  endfunction

  task automatic model_reset();
    xs.delete();
    sf.delete();
    e_idx   = 0;
    pend    = 0;
    exp_clk = 0;
    exp_out = '0;
  endtask

  // N-th order running sum at index e is sum_j x[j]*C(e-j, N-1); the comb output is the N-th
  // binomial difference of those sums taken at successive frame ends.
  task automatic model_edge();
    longint s, c, y;
    int m, sh;
    if (e_idx == 0) begin
      cur_r     = reff(decimation_ratio);
      frame_end = cur_r - 1;
    end
    xs.push_back(longint'(d_in));
    exp_clk = pend;
    if (pend) exp_out = pend_val;
    pend = 0;
    if (e_idx == frame_end) begin
      s = 0;
      for (int j = 0; j <= e_idx - N; j++) s += xs[j] * binom(longint'(e_idx - 1 - j), N - 1);
      sf.push_back(s);
      m = sf.size() - 1;
      c = 0;
      for (int k = 0; k <= N; k++)
        if (m - k >= 0) c += ((k % 2 == 1) ? -1 : 1) * binom(longint'(N), k) * sf[m - k];
      c  = c & ((longint'(1) << W) - 1);
      sh = N * clog2i(cur_r);
      y  = (sh >= 62) ? 0 : (c >> sh);
`ifdef CIC_SAT_EN
      pend_val = (y > 255) ? 8'd255 : 8'(y);
`else
      pend_val = 8'(y);
`endif
      pend      = 1;
      cur_r     = reff(decimation_ratio);
      frame_end = e_idx + cur_r;
    end
    e_idx++;
  endtask

  task automatic tick(input logic [7:0] din, input string tag);
    d_in = din;
    @(posedge clk);
    model_edge();
    #1;
    check({tag, " d_clk"}, longint'(d_clk), longint'(exp_clk));
    check({tag, " d_out"}, longint'(d_out), longint'(exp_out));
  endtask

  task automatic wait_pulse(input logic [7:0] din, input string tag, output int n);
    n = 0;
    do begin
      tick(din, tag);
      n++;
    end while (!d_clk && n < 100);
    if (!d_clk) check({tag, " pulse seen"}, longint'(d_clk), 1);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset async d_out", longint'(d_out), 0);
    check("reset async d_clk", longint'(d_clk), 0);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check("reset held d_out", longint'(d_out), 0);
      check("reset held d_clk", longint'(d_clk), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    int n;
    vecs[0] = '{16'd4, 8'd100, 8'd100, 4};
    vecs[1] = '{16'd8, 8'd37,  8'd37,  8};
    vecs[2] = '{16'd8, 8'd255, 8'd255, 8};
    vecs[3] = '{16'd3, 8'd255, 8'd107, 3};
    vecs[4] = '{16'd2, 8'd50,  8'd50,  2};
    vecs[5] = '{16'd5, 8'd200, 8'd48,  5};
    vecs[6] = '{16'd1, 8'd77,  8'd77,  1};

    model_reset();
    for (int i = 0; i < 7; i++) begin
      do_reset(2);
      decimation_ratio = vecs[i].ratio;
      for (int p = 0; p < N + 1; p++) wait_pulse(vecs[i].din, "settle", n);
      for (int p = 0; p < 3; p++) begin
        wait_pulse(vecs[i].din, "meas", n);
        check($sformatf("vec%0d period", i), n, vecs[i].period);
        check($sformatf("vec%0d settled d_out", i), longint'(d_out), longint'(vecs[i].exp_out));
      end
    end

    // R=0 and R=1: a pulse every cycle, output is the ramp delayed by the pipeline.
    for (int r = 0; r < 2; r++) begin
      do_reset(2);
      decimation_ratio = 16'(r);
      for (int t = 0; t < 40; t++) begin
        tick(8'(t), "ramp");
        if (t >= 1) check($sformatf("ramp r%0d d_clk", r), longint'(d_clk), 1);
        check($sformatf("ramp r%0d d_out t%0d", r, t), longint'(d_out), (t >= 4) ? t - 4 : 0);
      end
    end

    // DC step at R=8: 37 then 255.
    do_reset(2);
    decimation_ratio = 16'd8;
    for (int p = 0; p < N + 2; p++) wait_pulse(8'd37, "step37", n);
    check("step37 settled", longint'(d_out), 37);
    for (int p = 0; p < N + 2; p++) wait_pulse(8'd255, "step255", n);
    for (int p = 0; p < 2; p++) begin
      wait_pulse(8'd255, "step255", n);
      check("step255 settled", longint'(d_out), 255);
    end

    // Ratio change 4 -> 2 in the middle of a frame.
    do_reset(2);
    decimation_ratio = 16'd4;
    for (int p = 0; p < N + 3; p++) wait_pulse(8'd50, "rc4", n);
    tick(8'd50, "rc4");
    decimation_ratio = 16'd2;
    wait_pulse(8'd50, "rc", n);
    check("ratio change old period", n + 1, 4);
    for (int p = 0; p < 2; p++) begin
      wait_pulse(8'd50, "rc2", n);
      check("ratio change new period", n, 2);
    end
    for (int p = 0; p < N + 1; p++) wait_pulse(8'd50, "rc2", n);
    check("ratio change settled d_out", longint'(d_out), 50);

    // Reset mid-stream, then latency to the first pulse.
    do_reset(2);
    decimation_ratio = 16'd4;
    for (int t = 0; t < 40; t++) tick(8'd200, "pre-reset");
    check("pre-reset d_out", longint'(d_out), 200);
    do_reset(3);
    wait_pulse(8'd200, "post-reset", n);
    check("post-reset first pulse latency", n, 5);

    // Random samples with random ratio changes.
    do_reset(2);
    decimation_ratio = 16'($urandom_range(0, 8));
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 19) == 0) decimation_ratio = 16'($urandom_range(0, 8));
      tick(8'($urandom_range(0, 255)), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
